// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits LATENCY cycles,
// then performs the access and returns a one-cycle registered response.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic          cap_write;
  logic [2:0]    cap_funct3;
  logic [31:0]   cap_addr;
  logic [31:0]   cap_wdata;

  logic [31:0]   mem [DEPTH_WORDS];

  logic [AW-1:0] idx;
  logic [31:0]   rd_word;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic [31:0]   load_val;
  logic          range_err;
  logic          align_err;
  logic          funct3_err;
  logic          access_err;
  logic [3:0]    be;
  logic [31:0]   wlanes;
  logic          commit;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_comb begin
    idx        = cap_addr[AW+1:2];
    rd_word    = mem[idx];
    range_err  = |cap_addr[31:AW+2];
    align_err  = 1'b0;
    case (cap_funct3[1:0])
      2'b01:   align_err = cap_addr[0];
      2'b10:   align_err = |cap_addr[1:0];
      default: align_err = 1'b0;
    endcase
    // loads: 011, 110, 111 are illegal; stores: only 000..010 are legal
    funct3_err = cap_write ? (cap_funct3 > 3'd2)
                           : ((cap_funct3[1:0] == 2'b11) || (cap_funct3 == 3'b110));
    access_err = range_err || align_err || funct3_err;

    case (cap_addr[1:0])
      2'b00:   byte_v = rd_word[7:0];
      2'b01:   byte_v = rd_word[15:8];
      2'b10:   byte_v = rd_word[23:16];
      default: byte_v = rd_word[31:24];
    endcase
    half_v = cap_addr[1] ? rd_word[31:16] : rd_word[15:0];

    case (cap_funct3)
      3'b000:  load_val = {{24{byte_v[7]}}, byte_v};
      3'b001:  load_val = {{16{half_v[15]}}, half_v};
      3'b010:  load_val = rd_word;
      3'b100:  load_val = {24'd0, byte_v};
      3'b101:  load_val = {16'd0, half_v};
      default: load_val = '0;
    endcase

    be     = 4'b0000;
    wlanes = cap_wdata;
    case (cap_funct3[1:0])
      2'b00: begin
        be     = 4'b0001 << cap_addr[1:0];
        wlanes = {4{cap_wdata[7:0]}};
      end
      2'b01: begin
        be     = cap_addr[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{cap_wdata[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase

    commit = (state == WAIT) && (cnt == 4'd0) && !rst && cap_write && !access_err;
  end

  // Storage is deliberately not reset; only committed stores touch it.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][i*8 +: 8] <= wlanes[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          rsp_valid <= 1'b0;
          if (req_valid) begin
            cap_write  <= req_write;
            cap_funct3 <= req_funct3;
            cap_addr   <= req_addr;
            cap_wdata  <= req_wdata;
            cnt        <= 4'(LATENCY - 1);
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            rsp_valid <= 1'b1;
            rsp_err   <= access_err;
            rsp_rdata <= (cap_write || access_err) ? '0 : load_val;
            state     <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: byte-addressed reference model checked every
// cycle, plus literal expectations for the documented load/store scenarios.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned L     = 2;
  localparam int unsigned NBYTES = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int ncyc = 0;
  always @(posedge clk) ncyc <= ncyc + 1;

  int vectors = 0;
  int miscompares = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, ncyc, act, exp);
    end
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    bit          w;
    bit [2:0]    f3;
    bit [31:0]   a;
    bit [31:0]   d;
  } pend_t;

  pend_t       q[$];
  logic [7:0]  mb [NBYTES];
  bit          kn [NBYTES];
  bit          started = 0;
  int          free_at = 0;
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;
  bit          last_known = 0;

  task automatic model_access(input pend_t p);
    int unsigned sz;
    bit          legal, e, known;
    logic [31:0] v, mask;
    sz    = 1 << p.f3[1:0];
    legal = p.w ? (p.f3 <= 3'd2) : (p.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    e     = !legal || ((p.a % sz) != 0) || (p.a >= NBYTES);
    v     = '0;
    known = 1;
    if (!e && p.w) begin
      for (int unsigned i = 0; i < sz; i++) begin
        mb[p.a + i] = p.d[8*i +: 8];
        kn[p.a + i] = 1;
      end
    end else if (!e) begin
      for (int unsigned i = 0; i < sz; i++) begin
        v = v | (32'(mb[p.a + i]) << (8 * i));
        if (!kn[p.a + i]) known = 0;
      end
      if (!p.f3[2] && sz < 4) begin
        mask = (32'h1 << (8 * sz)) - 1;
        if (v[8*sz-1]) v = v | ~mask;
      end
    end
    last_rdata = (e || p.w) ? 32'h0 : v;
    last_err   = e;
    last_known = e || p.w || known;
  endtask

  always @(negedge clk) begin
    pend_t p;
    bit    exp_v;
    if (started) begin
      exp_v = 0;
      if (q.size() > 0 && q[0].due == ncyc) begin
        p = q.pop_front();
        exp_v = 1;
        model_access(p);
      end
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_v));
      chk("rsp_err", 32'(rsp_err), 32'(last_err));
      if (last_known) chk("rsp_rdata", rsp_rdata, last_rdata);
      chk("req_ready", 32'(req_ready), 32'(ncyc >= free_at));
      chk("busy", 32'(busy), 32'(ncyc < free_at));
    end
    if (rst) begin
      started    = 1;
      q.delete();
      free_at    = ncyc + 1;
      last_rdata = '0;
      last_err   = 1'b0;
      last_known = 1;
    end else if (started && req_valid && ncyc >= free_at) begin
      p.due = ncyc + L + 1;
      p.w   = req_write;
      p.f3  = req_funct3;
      p.a   = req_addr;
      p.d   = req_wdata;
      q.push_back(p);
      free_at = ncyc + L + 2;
    end
  end

  // ---------------- driver ----------------
  int last_acc = 0;

  task automatic wait_accept(output bit ok);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1;
        last_acc = ncyc;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_req(input bit w, input bit [2:0] f3, input bit [31:0] a,
                        input bit [31:0] d, input bit [31:0] exp_rd, input bit exp_e,
                        input string nm);
    bit ok, seen;
    int acc;
    req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d; req_valid = 1'b1;
    wait_accept(ok);
    acc = last_acc;
    @(posedge clk); #1 req_valid = 1'b0;
    if (!ok) return;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1;
        chk({nm, "_lat"}, 32'(ncyc - acc), 32'(L + 1));
        chk({nm, "_rdata"}, rsp_rdata, exp_rd);
        chk({nm, "_err"}, 32'(rsp_err), 32'(exp_e));
      end
    end
    if (!seen) chk({nm, "_rsp_timeout"}, 32'd0, 32'd1);
  endtask

  int acc_t[3];

  initial begin
    bit ok;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", 32'(req_ready), 32'd1);
    chk("reset_rdata", rsp_rdata, 32'd0);

    do_req(1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0, "sw10");
    do_req(0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0, "lw10");
    do_req(1, 3'b000, 32'h11, 32'h80, 32'h0, 0, "sb11");
    do_req(0, 3'b000, 32'h11, 32'h0, 32'hFFFFFF80, 0, "lb11");
    do_req(0, 3'b100, 32'h11, 32'h0, 32'h00000080, 0, "lbu11");
    do_req(0, 3'b010, 32'h10, 32'h0, 32'hDEAD80EF, 0, "lw10b");
    do_req(0, 3'b001, 32'h13, 32'h0, 32'h0, 1, "lh13_mis");
    do_req(1, 3'b010, 32'h12, 32'h11111111, 32'h0, 1, "sw12_mis");
    do_req(0, 3'b010, 32'h10, 32'h0, 32'hDEAD80EF, 0, "lw10c");
    do_req(0, 3'b010, 32'h1000, 32'h0, 32'h0, 1, "lw_oor");
    do_req(0, 3'b011, 32'h10, 32'h0, 32'h0, 1, "ld_f3_011");
    do_req(1, 3'b011, 32'h10, 32'h0, 32'h0, 1, "st_f3_011");
    do_req(1, 3'b010, 32'h14, 32'h0, 32'h0, 0, "sw14");
    do_req(1, 3'b001, 32'h16, 32'hABCD1234, 32'h0, 0, "sh16");
    do_req(0, 3'b010, 32'h14, 32'h0, 32'h12340000, 0, "lw14");
    do_req(1, 3'b001, 32'h18, 32'h8001, 32'h0, 0, "sh18");
    do_req(0, 3'b001, 32'h18, 32'h0, 32'hFFFF8001, 0, "lh18");
    do_req(0, 3'b101, 32'h18, 32'h0, 32'h00008001, 0, "lhu18");
    do_req(0, 3'b110, 32'h18, 32'h0, 32'h0, 1, "ld_f3_110");
    do_req(1, 3'b010, 32'hFFC, 32'h0BADF00D, 32'h0, 0, "sw_top");
    do_req(0, 3'b100, 32'hFFF, 32'h0, 32'h0000000B, 0, "lbu_top");
    do_req(0, 3'b010, 32'h80000FFC, 32'h0, 32'h0, 1, "lw_hibit");

    // back-to-back with req_valid held high
    req_write = 0; req_funct3 = 3'b010; req_wdata = '0; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_addr = 32'h10 + 32'(4 * i);
      wait_accept(ok);
      acc_t[i] = last_acc;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    chk("b2b_gap1", 32'(acc_t[1] - acc_t[0]), 32'(L + 2));
    chk("b2b_gap2", 32'(acc_t[2] - acc_t[1]), 32'(L + 2));
    repeat (L + 3) @(negedge clk);

    // reset during WAIT aborts the store
    do_req(1, 3'b010, 32'h20, 32'hCAFEF00D, 32'h0, 0, "sw20");
    req_write = 1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h12345678;
    req_valid = 1'b1;
    wait_accept(ok);
    @(posedge clk); #1 req_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < L + 2; i++) begin
      @(negedge clk);
      chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
    end
    do_req(0, 3'b010, 32'h20, 32'h0, 32'hCAFEF00D, 0, "lw20_after_abort");

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout at cycle %0d", ncyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024, giving the number of 32-bit words of storage; the legal range is a power of 2 from 4 to 65536.
REQ-002 The block SHALL have parameter LATENCY, default 2, giving the number of WAIT cycles per access; the legal range is 1 to 15.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port req_valid, input, 1 bit: the initiator presents a request.
REQ-006 The block SHALL have port req_ready, output, 1 bit: the block can accept a request.
REQ-007 The block SHALL have port req_write, input, 1 bit: 1 = store (mem_write), 0 = load (mem_read).
REQ-008 The block SHALL have port req_funct3, input, 3 bits: the instr[14:12] access size and sign code.
REQ-009 The block SHALL have port req_addr, input, 32 bits: the byte address (ALU result).
REQ-010 The block SHALL have port req_wdata, input, 32 bits: the store data (rs2), LSB-aligned.
REQ-011 The block SHALL have port rsp_valid, output, 1 bit: a one-cycle response strobe.
REQ-012 The block SHALL have port rsp_rdata, output, 32 bits: load data after extension; 0 for stores and errors.
REQ-013 The block SHALL have port rsp_err, output, 1 bit: the access faulted; qualified by rsp_valid.
REQ-014 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT and RESP; req_ready SHALL be high only in IDLE.
REQ-016 A request SHALL be accepted on a rising edge where req_valid && req_ready; the block SHALL capture req_write, req_funct3, req_addr and req_wdata, load the wait counter with LATENCY-1, and move to WAIT.
REQ-017 In WAIT, the counter SHALL decrement each cycle; on the edge where counter==0 the block SHALL perform the access and move to RESP.
REQ-018 rsp_valid SHALL be high for exactly the one cycle spent in RESP; the next edge SHALL return the FSM to IDLE.
REQ-019 With acceptance at edge k, rsp_valid SHALL be high in the cycle following edge k+LATENCY, and req_ready SHALL be high again after edge k+LATENCY+1.
REQ-020 While not in IDLE, req_valid SHALL be ignored; no queueing, and the initiator holds its request until it is accepted.
REQ-021 Load funct3 decoding SHALL be: 000 LB sign-extend byte; 001 LH sign-extend half; 010 LW; 100 LBU zero-extend byte; 101 LHU zero-extend half; 011, 110 and 111 illegal.
REQ-022 Store funct3 decoding SHALL be: 000 SB writes req_wdata[7:0]; 001 SH writes [15:0]; 010 SW writes [31:0]; any other value is illegal.
REQ-023 A store SHALL write only the addressed byte lanes (byte lane = addr[1:0], half lane = addr[1]); all other lanes of the word SHALL be unchanged.
REQ-024 Loads SHALL extract the addressed lane and shift it to bit 0 before extension.
REQ-025 The word index SHALL be addr[log2(DEPTH_WORDS)+1:2].
REQ-026 An out-of-range address (any addr bit at or above log2(DEPTH_WORDS)+2 set) SHALL raise an error; there SHALL be no wrap-around.
REQ-027 A misaligned access SHALL raise an error: a half access with addr[0]=1, or a word access with addr[1:0]!=0.
REQ-028 An illegal funct3 SHALL raise an error.
REQ-029 When an error is raised, rsp_err SHALL be 1 in RESP, no storage SHALL be modified, and rsp_rdata SHALL be 0.
REQ-030 rsp_rdata and rsp_err SHALL be registered, SHALL hold their last value outside RESP, and SHALL be 0 for stores.
REQ-031 A load issued directly after a store to the same word SHALL return the updated data, because the store commits before the load is accepted.

Reset
REQ-032 When rst=1 at a rising edge, the FSM SHALL go to IDLE, the counter SHALL clear to 0, rsp_valid, rsp_err, rsp_rdata and busy SHALL be 0, and req_ready SHALL be 1 in the following cycle.
REQ-033 Reset asserted in WAIT SHALL abort the access: no store commits, and no rsp_valid is produced.
REQ-034 Reset asserted in RESP SHALL suppress further rsp_valid.
REQ-035 Storage contents SHALL NOT be reset; a load from a never-written word returns an undefined value and rsp_err=0.
REQ-036 rst SHALL have priority over req_valid on the same edge.

Verification
REQ-037 Scenario (defaults): SW addr=0x10, wdata=0xDEADBEEF, then LW addr=0x10 -> rsp_valid 3 cycles after each acceptance; rdata=0xDEADBEEF, err=0.
REQ-038 Scenario: after the previous scenario, SB addr=0x11, wdata=0x80, then LB 0x11 -> 0xFFFFFF80; LBU 0x11 -> 0x00000080; LW 0x10 -> 0xDEAD80EF.
REQ-039 Scenario: LH addr=0x13, then SW addr=0x12 -> both give err=1 and rdata=0; LW 0x10 still returns 0xDEAD80EF.
REQ-040 Scenario: LW addr=0x1000 with DEPTH_WORDS=1024 -> err=1; a load with funct3=011 -> err=1.
REQ-041 Scenario: req_valid held high continuously with back-to-back requests -> one acceptance every LATENCY+2 cycles, and req_ready=0 throughout WAIT and RESP.
REQ-042 Scenario: SW addr=0x20, wdata=0x12345678, with rst pulsed in the WAIT cycle -> no rsp_valid; a subsequent LW 0x20 returns the value held before that store.
